// File: rtl/mux_two_arbiter_pkg.sv
// Shared encodings and default widths for the two-input burst arbiter.
// The FSM encoding stays in plain localparams so older blocks can read it directly.
package svd_pkg;
  localparam int DATA_WIDTH = 256;
  localparam int MAX_BURST  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL0 = 2'd1;
  localparam logic [1:0] ST_SEL1 = 2'd2;

  // A grant ends on the requester's last beat or when the beat count reaches the cap.
  function automatic logic burst_end(input logic last, input logic [7:0] cnt_inc,
                                     input logic [7:0] cap);
    return last || (cnt_inc == cap);
  endfunction
endpackage

// File: rtl/mux_two_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream sink.
interface mux_two_arbiter_if #(parameter int data_width = svd_pkg::DATA_WIDTH);
  logic                  in0_valid;
  logic                  in1_valid;
  logic                  in0_last;
  logic                  in1_last;
  logic [data_width-1:0] in0;
  logic [data_width-1:0] in1;
  logic                  in0_ready;
  logic                  in1_ready;
  logic                  out_valid;
  logic                  out_last;
  logic [data_width-1:0] out0;
  logic                  out_ready;
  logic                  mux_two;
  logic                  busy;

  modport slave (
    input  in0_valid, in1_valid, in0_last, in1_last, in0, in1, out_ready,
    output in0_ready, in1_ready, out_valid, out_last, out0, mux_two, busy
  );

  modport master (
    output in0_valid, in1_valid, in0_last, in1_last, in0, in1, out_ready,
    input  in0_ready, in1_ready, out_valid, out_last, out0, mux_two, busy
  );
endinterface

// File: rtl/mux_two_arbiter_mux_two_ins.sv
// Plain two-input data mux; sel = 1 picks in1.
module mux_two_ins #(
  parameter int data_width = svd_pkg::DATA_WIDTH
) (
  input  logic                  sel,
  input  logic [data_width-1:0] in0,
  input  logic [data_width-1:0] in1,
  output logic [data_width-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux_two_arbiter.sv
// Round-robin burst arbiter for two requesters with a single registered output beat.
// Every release passes through IDLE for one cycle before the next grant.
import svd_pkg::*;

module mux_two_arbiter #(
  parameter int data_width = DATA_WIDTH,
  parameter int max_burst  = MAX_BURST
) (
  input logic            clk,
  input logic            rst,
  mux_two_arbiter_if.slave bus
);
  localparam logic [7:0] CAP = 8'(max_burst);

  logic [1:0]            state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [data_width-1:0] out0_q, out0_d;
  logic                  mux_two_q, mux_two_d;

  logic [data_width-1:0] sel_data;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  can_load;
  logic                  xfer;
  logic [7:0]            cnt_inc;

  mux_two_ins #(.data_width(data_width)) u_mux (
    .sel (mux_two_q),
    .in0 (bus.in0),
    .in1 (bus.in1),
    .out (sel_data)
  );

  // The output slot can take a beat if it is empty or draining this cycle.
  assign can_load     = !out_valid_q || bus.out_ready;
  assign bus.in0_ready = !rst && (state_q == ST_SEL0) && can_load;
  assign bus.in1_ready = !rst && (state_q == ST_SEL1) && can_load;

  // mux_two_q always matches the granted side while in SELx.
  assign sel_valid = mux_two_q ? bus.in1_valid : bus.in0_valid;
  assign sel_last  = mux_two_q ? bus.in1_last  : bus.in0_last;
  assign xfer      = (bus.in0_valid && bus.in0_ready) || (bus.in1_valid && bus.in1_ready);
  assign cnt_inc   = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mux_two_d = mux_two_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        // ptr_q = 0 favours in0 on a tie.
        if (bus.in0_valid && (!bus.in1_valid || !ptr_q)) begin
          state_d   = ST_SEL0;
          ptr_d     = 1'b1;
          mux_two_d = 1'b0;
        end else if (bus.in1_valid) begin
          state_d   = ST_SEL1;
          ptr_d     = 1'b0;
          mux_two_d = 1'b1;
        end
      end
      ST_SEL0, ST_SEL1: begin
        if (!sel_valid) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (xfer) begin
          if (burst_end(sel_last, cnt_inc, CAP)) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out0_d      = out0_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_last_d  = sel_last;
      out0_d      = sel_data;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out0_q      <= '0;
      mux_two_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out0_q      <= out0_d;
      mux_two_q   <= mux_two_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out0      = out0_q;
  assign bus.mux_two   = mux_two_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mux_two_arbiter.sv
// Directed bench for mux_two_arbiter: a max_burst = 8 instance plus a max_burst = 1 instance.
module tb_mux_two_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_two_arbiter_if #(.data_width(256)) bif ();
  mux_two_arbiter_if #(.data_width(256)) bif1 ();

  mux_two_arbiter #(.data_width(256), .max_burst(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  mux_two_arbiter #(.data_width(256), .max_burst(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bif1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bif.in0_valid  = 1'b0; bif.in1_valid  = 1'b0;
    bif.in0_last   = 1'b0; bif.in1_last   = 1'b0;
    bif.in0        = '0;   bif.in1        = '0;
    bif.out_ready  = 1'b1;
    bif1.in0_valid = 1'b0; bif1.in1_valid = 1'b0;
    bif1.in0_last  = 1'b0; bif1.in1_last  = 1'b0;
    bif1.in0       = '0;   bif1.in1       = '0;
    bif1.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    clr_inputs();
    do_reset();

    // Reset state
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_out_last",  64'(bif.out_last), 64'd0);
    chk("rst_out0_zero", 64'(bif.out0 == '0), 64'd1);
    chk("rst_mux_two",   64'(bif.mux_two), 64'd0);
    chk("rst_busy",      64'(bif.busy), 64'd0);
    chk("rst_busy_b1",   64'(bif1.busy), 64'd0);

    // Scenario 1: single requester, three beats
    bif.in0_valid = 1'b1; bif.in0 = 256'hA1;
    #1;
    chk("s1_idle_ready", 64'(bif.in0_ready), 64'd0);
    tick();
    chk("s1_grant_busy", 64'(bif.busy), 64'd1);
    chk("s1_grant_rdy",  64'(bif.in0_ready), 64'd1);
    chk("s1_no_out_yet", 64'(bif.out_valid), 64'd0);
    tick();
    chk("s1_b1", bif.out0[63:0], 64'hA1);
    chk("s1_b1_valid", 64'(bif.out_valid), 64'd1);
    chk("s1_b1_last", 64'(bif.out_last), 64'd0);
    bif.in0 = 256'hA2;
    tick();
    chk("s1_b2", bif.out0[63:0], 64'hA2);
    bif.in0 = 256'hA3; bif.in0_last = 1'b1;
    tick();
    chk("s1_b3", bif.out0[63:0], 64'hA3);
    chk("s1_b3_last", 64'(bif.out_last), 64'd1);
    chk("s1_mux_two", 64'(bif.mux_two), 64'd0);
    chk("s1_end_idle", 64'(bif.busy), 64'd0);
    bif.in0_valid = 1'b0; bif.in0_last = 1'b0;
    tick();
    chk("s1_drain", 64'(bif.out_valid), 64'd0);

    // Scenario 2: tie from reset, single-beat bursts alternate
    do_reset();
    bif.in0_valid = 1'b1; bif.in0_last = 1'b1; bif.in0 = 256'hB0;
    bif.in1_valid = 1'b1; bif.in1_last = 1'b1; bif.in1 = 256'hB1;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("s2_busy", 64'(bif.busy), 64'd1);
      chk("s2_sel", 64'(bif.mux_two), 64'(g % 2));
      chk("s2_other_rdy", 64'((g % 2) ? bif.in0_ready : bif.in1_ready), 64'd0);
      tick();
      chk("s2_data", bif.out0[63:0], (g % 2) ? 64'hB1 : 64'hB0);
      chk("s2_gap_idle", 64'(bif.busy), 64'd0);
    end

    // Scenario 3: cap at 8 beats, then re-grant for the remainder
    do_reset();
    bif.in1_valid = 1'b1;
    bif.in1 = 256'hC0;
    tick();
    chk("s3_grant", 64'(bif.mux_two), 64'd1);
    for (int b = 1; b <= 12; b++) begin
      bif.in1 = 256'(8'hC0 + b - 1);
      bif.in1_last = (b == 12);
      tick();
      chk("s3_data", bif.out0[63:0], 64'(8'hC0 + b - 1));
      if (b == 8) begin
        chk("s3_cap_release", 64'(bif.busy), 64'd0);
        tick();
        chk("s3_regrant", 64'(bif.busy), 64'd1);
        chk("s3_regrant_sel", 64'(bif.mux_two), 64'd1);
        chk("s3_gap_drain", 64'(bif.out_valid), 64'd0);
      end else if (b == 12) begin
        chk("s3_last", 64'(bif.out_last), 64'd1);
        chk("s3_end", 64'(bif.busy), 64'd0);
      end else begin
        chk("s3_hold_grant", 64'(bif.busy), 64'd1);
      end
    end
    bif.in1_valid = 1'b0; bif.in1_last = 1'b0;

    // Scenario 4: backpressure after beat 2; the cap still lands on beat 8
    do_reset();
    bif.in0_valid = 1'b1;
    tick();
    for (int b = 1; b <= 8; b++) begin
      bif.in0 = 256'(8'hD0 + b - 1);
      if (b == 3) begin
        bif.out_ready = 1'b0;
        #1;
        chk("s4_stall_rdy", 64'(bif.in0_ready), 64'd0);
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("s4_hold_data", bif.out0[63:0], 64'hD1);
          chk("s4_hold_valid", 64'(bif.out_valid), 64'd1);
          chk("s4_hold_grant", 64'(bif.busy), 64'd1);
        end
        bif.out_ready = 1'b1;
      end
      tick();
      chk("s4_data", bif.out0[63:0], 64'(8'hD0 + b - 1));
      chk("s4_busy", 64'(bif.busy), (b == 8) ? 64'd0 : 64'd1);
    end
    bif.in0_valid = 1'b0;

    // Scenario 5: reset after beat 3 of 6 while the sink stalls
    do_reset();
    bif.in0_valid = 1'b1;
    tick();
    for (int b = 1; b <= 3; b++) begin
      bif.in0 = 256'(8'hE0 + b - 1);
      tick();
    end
    chk("s5_pre_data", bif.out0[63:0], 64'hE2);
    bif.in0 = 256'hE3;
    rst = 1'b1;
    #1;
    chk("s5_rst_rdy", 64'(bif.in0_ready), 64'd0);
    bif.out_ready = 1'b0;
    tick();
    chk("s5_valid", 64'(bif.out_valid), 64'd0);
    chk("s5_last", 64'(bif.out_last), 64'd0);
    chk("s5_out0", 64'(bif.out0 == '0), 64'd1);
    chk("s5_busy", 64'(bif.busy), 64'd0);
    chk("s5_mux", 64'(bif.mux_two), 64'd0);
    rst = 1'b0; bif.out_ready = 1'b1;
    bif.in0 = 256'hF0; bif.in0_last = 1'b1;
    tick();
    chk("s5_new_grant", 64'(bif.busy), 64'd1);
    tick();
    chk("s5_new_data", bif.out0[63:0], 64'hF0);
    chk("s5_new_last", 64'(bif.out_last), 64'd1);
    bif.in0_valid = 1'b0; bif.in0_last = 1'b0;

    // Scenario 6: in1 drops valid after 2 beats with in0 waiting
    do_reset();
    bif.in1_valid = 1'b1;
    tick();
    bif.in1 = 256'h60;
    tick();
    bif.in1 = 256'h61;
    tick();
    chk("s6_b2", bif.out0[63:0], 64'h61);
    bif.in1_valid = 1'b0;
    bif.in0_valid = 1'b1; bif.in0 = 256'h70; bif.in0_last = 1'b1;
    #1;
    chk("s6_wait_rdy", 64'(bif.in0_ready), 64'd0);
    tick();
    chk("s6_idle", 64'(bif.busy), 64'd0);
    chk("s6_mux_hold", 64'(bif.mux_two), 64'd1);
    tick();
    chk("s6_sel0", 64'(bif.busy), 64'd1);
    chk("s6_mux0", 64'(bif.mux_two), 64'd0);
    tick();
    chk("s6_data", bif.out0[63:0], 64'h70);
    bif.in0_valid = 1'b0; bif.in0_last = 1'b0;

    // Scenario 7: max_burst = 1 alternates on every grant without last
    do_reset();
    bif1.in0_valid = 1'b1; bif1.in0 = 256'h10;
    bif1.in1_valid = 1'b1; bif1.in1 = 256'h11;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("s7_sel", 64'(bif1.mux_two), 64'(g % 2));
      tick();
      chk("s7_data", bif1.out0[63:0], (g % 2) ? 64'h11 : 64'h10);
      chk("s7_release", 64'(bif1.busy), 64'd0);
    end
    clr_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_two_arbiter.md
MUX_TWO_ARBITER -- requirements
Module: mux_two_arbiter

Interface
REQ-001 Parameter data_width, default 256, width of every data bus.
REQ-002 Parameter max_burst, default 8, maximum beats per grant before forced re-arbitration; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in0_valid / in1_valid  input  1  requester 0 / 1 has a beat.
REQ-006 in0_last / in1_last  input  1  beat ends requester's burst.
REQ-007 in0 / in1  input  data_width  requester 0 / 1 data.
REQ-008 in0_ready / in1_ready  output  1  beat accepted when valid && ready at the clock edge.
REQ-009 out_valid  output  1  registered output beat present.
REQ-010 out_last  output  1  registered copy of accepted beat's last.
REQ-011 out0  output  data_width  registered accepted data.
REQ-012 out_ready  input  1  downstream accepts the out beat.
REQ-013 mux_two  output  1  current select; 0 = in0, 1 = in1.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, SEL0, SEL1.
REQ-016 IDLE: only in0_valid -> SEL0; only in1_valid -> SEL1; neither -> stay in IDLE.
REQ-017 IDLE with both valid: grant the requester not served last (round-robin pointer); after reset the pointer favours in0.
REQ-018 Pointer updates on entry to SELx so that the other requester wins the next tie.
REQ-019 inX_ready = (state == SELX) && (!out_valid || out_ready); the non-granted ready is always 0; both readys are 0 in IDLE.
REQ-020 On a transfer, the output register loads in-data, last, and out_valid = 1 on the same edge.
REQ-021 out_valid clears when out_ready = 1 and no new transfer occurs in that cycle.
REQ-022 The output register holds stable while out_valid && !out_ready.
REQ-023 Latency is 1 cycle from transfer edge to out_valid.
REQ-024 Minimum latency from request to output: request first seen in IDLE at cycle t -> SELx at t+1 -> transfer at t+1 -> out_valid at t+2.
REQ-025 Beat counter increments per transfer in SELx and clears on leaving SELx.
REQ-026 SELx -> IDLE after a transfer with inX_last = 1.
REQ-027 SELx -> IDLE after the transfer that makes the counter equal max_burst.
REQ-028 SELx -> IDLE on any cycle in which inX_valid = 0 (implicit burst end).
REQ-029 Leaving SELx always inserts exactly one IDLE cycle before the next grant.
REQ-030 mux_two = 1 in SEL1 and 0 in SEL0; in IDLE it holds its previous value.
REQ-031 A last beat and the max_burst cap on the same transfer cause a single release, not a double one.
REQ-032 Backpressure (out_ready = 0) while granted keeps the grant and does not advance the counter.
REQ-033 With max_burst = 1, back-to-back requesters alternate every grant.

Reset
REQ-034 When rst is sampled high, the next state is: IDLE; pointer favours in0; counter 0; out_valid 0; out_last 0; out0 all zeros; mux_two 0; busy 0.
REQ-035 Reset mid-burst discards the burst; the output register is cleared even while out_valid && !out_ready.
REQ-036 Both readys are 0 during any cycle in which rst is high.

Structure
REQ-037 The shared package svd_pkg holds the FSM state encoding and default widths (DATA_WIDTH = 256, MAX_BURST = 8).
REQ-038 Data selection instantiates the existing two-input mux sub-module mux_two_ins, with its select driven by mux_two.
REQ-039 The FSM, pointer, counter and output register live in this module; no other sub-modules.

Verification
REQ-040 Scenario 1, single requester: in0_valid with data 0xA1, 0xA2, 0xA3 (last on 0xA3), out_ready = 1 -> out0 = 0xA1, 0xA2, 0xA3 on consecutive cycles, out_last on the third, mux_two = 0, then IDLE.
REQ-041 Scenario 2, tie: both valid from reset, single-beat bursts -> grant order in0, in1, in0, in1 with one IDLE cycle between grants.
REQ-042 Scenario 3, cap: max_burst = 8, in1 streams 12 beats with no last, in0 idle -> release after beat 8, IDLE one cycle, re-grant to in1 for beats 9..12.
REQ-043 Scenario 4, backpressure: out_ready = 0 for 5 cycles mid-burst -> out0 holds value, in0_ready = 0, counter frozen, no beat lost or duplicated.
REQ-044 Scenario 5, reset mid-burst: rst pulsed after beat 3 of 6 with out_valid = 1 -> next cycle all outputs at reset values, then a new request is served normally.
REQ-045 Scenario 6, implicit end: in1 drops valid after 2 beats with in0 waiting -> IDLE one cycle, then SEL0, mux_two = 0.
